// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch front end for the RV32IM core. Holds the fetch PC, issues
// word requests to instruction memory (request/grant with in-order responses)
// and buffers the returned words together with their PCs. The decoder takes
// them over a valid/ready handshake. A branch/jump redirect from downstream
// reloads the PCs, flushes the buffer and drops every response still in flight.
//
// Parameters
//   RESET_PC   : first fetch address after reset
//   BUF_DEPTH  : instruction buffer entries (power of two, >= 2). This is also
//                the credit limit for buffered words plus outstanding requests.
//
// Ports
//   clk          in   core clock, all state on posedge
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  fetch request valid
//   imem_addr    out  request word address (bits [1:0] always 0)
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   response data valid (in request order)
//   imem_rdata   in   instruction word
//   redirect     in   taken branch/jump from decode/execute
//   redirect_pc  in   redirect target (bits [1:0] ignored)
//   inst_valid   out  inst/inst_pc valid toward the decoder
//   inst         out  instruction word
//   inst_pc      out  PC of inst
//   inst_ready   in   decoder accepts the instruction
//
// Optional feature (compile-time macro)
//   INST_FETCH_JAL_PREDECODE_EN : static JAL predecode. A JAL word that is kept
//   is still delivered, and in the same cycle fetch is steered to its target.
//   An external redirect in the same cycle wins. The decoder must compile out
//   its own JAL pc_sel term under the same macro.
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W   = (CW+1)'(BUF_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [31:0]   WORD_MASK = 32'hFFFF_FFFC;

    // Registered state
    logic              run_r;
    logic [31:0]       fetch_pc_r;
    logic [31:0]       resp_pc_r;
    logic [CW-1:0]     outstanding_r;
    logic [CW-1:0]     discard_r;
    logic [CW-1:0]     fifo_count_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [31:0]       pc_mem_r   [BUF_DEPTH];
    logic [31:0]       word_mem_r [BUF_DEPTH];

    // Combinational control
    logic [CW:0]       in_use_s;
    logic              fire_s;
    logic              keep_s;
    logic              drop_s;
    logic              push_s;
    logic              pop_s;
    logic              jal_hit_s;
    logic [31:0]       jal_tgt_s;
    logic [31:0]       redirect_tgt_s;
    logic [CW-1:0]     outstanding_n_s;
    logic [CW-1:0]     discard_n_s;
    logic [CW-1:0]     fifo_count_n_s;
    logic [31:0]       fetch_pc_n_s;
    logic [31:0]       resp_pc_n_s;

    // Request issue: credit covers buffered words plus requests still in flight
    always_comb begin
        in_use_s  = {1'b0, outstanding_r} + {1'b0, fifo_count_r};
        imem_req  = run_r && !redirect && (in_use_s < DEPTH_W);
        imem_addr = fetch_pc_r;
        fire_s    = imem_req && imem_gnt;
    end

    // Response classification and buffer handshake
    always_comb begin
        keep_s         = imem_rvalid && (discard_r == CNT_ZERO);
        drop_s         = imem_rvalid && (discard_r != CNT_ZERO);
        push_s         = keep_s && !redirect;
        pop_s          = inst_valid && inst_ready && !redirect;
        redirect_tgt_s = redirect_pc & WORD_MASK;
    end

`ifdef INST_FETCH_JAL_PREDECODE_EN
    logic [31:0] jal_imm_s;

    // JAL predecode: J-immediate relative to the PC of the word being kept
    always_comb begin
        jal_imm_s = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                     imem_rdata[20], imem_rdata[30:21], 1'b0};
        jal_tgt_s = (resp_pc_r + jal_imm_s) & WORD_MASK;
        jal_hit_s = push_s && (imem_rdata[6:0] == 7'b1101111);
    end
`else
    // JAL predecode disabled: JAL waits for the external redirect
    always_comb begin
        jal_tgt_s = 32'h0000_0000;
        jal_hit_s = 1'b0;
    end
`endif

    // Next-state for counters and PCs; redirect outranks everything
    always_comb begin
        outstanding_n_s = outstanding_r
                        + (fire_s      ? CNT_ONE : CNT_ZERO)
                        - (imem_rvalid ? CNT_ONE : CNT_ZERO);

        // Every response still owed after this cycle belongs to the old path,
        // including one granted this very cycle.
        if (redirect || jal_hit_s) begin
            discard_n_s = outstanding_n_s;
        end else if (drop_s) begin
            discard_n_s = discard_r - CNT_ONE;
        end else begin
            discard_n_s = discard_r;
        end

        if (redirect) begin
            fifo_count_n_s = CNT_ZERO;
        end else begin
            fifo_count_n_s = fifo_count_r
                           + (push_s ? CNT_ONE : CNT_ZERO)
                           - (pop_s  ? CNT_ONE : CNT_ZERO);
        end

        if (redirect) begin
            fetch_pc_n_s = redirect_tgt_s;
        end else if (jal_hit_s) begin
            fetch_pc_n_s = jal_tgt_s;
        end else if (fire_s) begin
            fetch_pc_n_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_n_s = fetch_pc_r;
        end

        // The JAL itself is pushed at the old resp_pc; the next kept word is
        // the first one fetched from its target.
        if (redirect) begin
            resp_pc_n_s = redirect_tgt_s;
        end else if (jal_hit_s) begin
            resp_pc_n_s = jal_tgt_s;
        end else if (push_s) begin
            resp_pc_n_s = resp_pc_r + 32'd4;
        end else begin
            resp_pc_n_s = resp_pc_r;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r         <= 1'b0;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            discard_r     <= CNT_ZERO;
            fifo_count_r  <= CNT_ZERO;
        end else begin
            run_r         <= 1'b1;
            fetch_pc_r    <= fetch_pc_n_s;
            resp_pc_r     <= resp_pc_n_s;
            outstanding_r <= outstanding_n_s;
            discard_r     <= discard_n_s;
            fifo_count_r  <= fifo_count_n_s;
        end
    end

    // Buffer pointers; a flush simply rewinds both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
        end else if (redirect) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Buffer storage; contents are only observed while inst_valid is high
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= resp_pc_r;
            word_mem_r[wr_ptr_r] <= imem_rdata;
        end
    end

    // Decoder-facing outputs from the buffer head, zero while empty
    always_comb begin
        inst_valid = (fifo_count_r != CNT_ZERO);
        if (inst_valid) begin
            inst    = word_mem_r[rd_ptr_r];
            inst_pc = pc_mem_r[rd_ptr_r];
        end else begin
            inst    = 32'h0000_0000;
            inst_pc = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    inst_fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    pend_t       pend_q[$];   // granted requests awaiting a memory response
    logic [63:0] exp_q[$];    // scoreboard: {pc, word} the decoder must see
    logic [31:0] exp_fetch;   // next address the fetch unit must request
    bit          resp_en;
    logic [31:0] cur_addr;
    bit          cur_stale;
    int          n_vec;
    int          n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs, update the model, then let memory respond
    task automatic cycle();
        logic        exp_req;
        logic        exp_valid;
        logic [63:0] e;
        pend_t       p;
        #1;
        exp_req   = !redirect &&
                    ((pend_q.size() + (imem_rvalid ? 1 : 0) + exp_q.size()) < 2);
        exp_valid = (exp_q.size() != 0);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        if (imem_req) begin
            chk("imem_addr", imem_addr, exp_fetch);
        end
        if (inst_valid && inst_ready && !redirect && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc, e[63:32]);
            chk("inst", inst, e[31:0]);
        end
        if (redirect) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_q.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
        end else begin
            if (imem_rvalid && !cur_stale) begin
                exp_q.push_back({cur_addr, imem_rdata});
            end
            if (imem_req && imem_gnt) begin
                p.addr  = imem_addr;
                p.stale = 1'b0;
                pend_q.push_back(p);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (resp_en && pend_q.size() > 0) begin
            p           = pend_q.pop_front();
            cur_addr    = p.addr;
            cur_stale   = p.stale;
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(p.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0000_0000;
        end
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0000_0000);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0000_0000);
        chk("rst_inst", inst, 32'h0000_0000);
        chk("rst_inst_pc", inst_pc, 32'h0000_0000);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        inst_ready  = 1'b0;
        resp_en     = 1'b1;
        cur_addr    = 32'h0000_0000;
        cur_stale   = 1'b0;
        exp_fetch   = RST_PC;

        // Reset state
        repeat (2) @(negedge clk);
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Streaming from RESET_PC with a 1-cycle memory
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        repeat (8) cycle();

        // Decoder stalls: buffer fills, requests stop, then resume
        inst_ready = 1'b0;
        repeat (6) cycle();
        chk("full_valid", {31'b0, inst_valid}, 32'h0000_0001);
        inst_ready = 1'b1;
        repeat (6) cycle();

        // Grant withheld: address must hold
        imem_gnt = 1'b0;
        repeat (3) cycle();
        imem_gnt = 1'b1;
        repeat (4) cycle();

        // Two requests in flight when the redirect hits
        resp_en = 1'b0;
        repeat (4) cycle();
        chk("two_in_flight", pend_q.size(), 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2003;
        cycle();
        redirect = 1'b0;
        resp_en  = 1'b1;
        repeat (8) cycle();

        // Redirect in a cycle carrying a response
        for (int i = 0; i < 10 && !imem_rvalid; i++) cycle();
        chk("resp_before_redirect", {31'b0, imem_rvalid}, 32'h0000_0001);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        cycle();
        redirect = 1'b0;
        repeat (6) cycle();

        // PC wraps at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        repeat (8) cycle();

        // Random grant/ready/latency with occasional redirects
        for (int i = 0; i < 300; i++) begin
            imem_gnt    = ($urandom_range(0, 3) != 0);
            inst_ready  = ($urandom_range(0, 2) != 0);
            resp_en     = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = $urandom;
            cycle();
        end
        redirect = 1'b0;

        // Reset in the middle of operation with a non-empty buffer
        imem_gnt   = 1'b0;
        inst_ready = 1'b0;
        resp_en    = 1'b1;
        repeat (4) cycle();
        rst_n = 1'b0;
        pend_q.delete();
        exp_q.delete();
        exp_fetch   = RST_PC;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        repeat (8) cycle();

        // Drain: every expected word must have been delivered
        imem_gnt = 1'b0;
        repeat (6) cycle();
        chk("drain_left", exp_q.size(), 32'd0);
        chk("drain_valid", {31'b0, inst_valid}, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
